// File: rtl/rr_port_scheduler.sv
// ---------------------------------------------------------------------------
// rr_port_scheduler
//
// Packet-aware round-robin scheduler for one router output port. Four input
// requesters share the port; a grant is held for a whole packet and ends on
// end-of-packet, on request withdrawal, or when the grant has lasted MAX_HOLD
// beats. After every release the requester just served becomes lowest
// priority, and the next winner (if any) is granted on the very next cycle.
//
// Ports
//   CLK            in   clock, all state changes on the rising edge
//   RST            in   synchronous active-high reset (wins over enable)
//   enable         in   active-high; low freezes all state (timeout_pulse
//                       still clears)
//   req_vector     in   [3:0] level request per requester
//   eop_vector     in   [3:0] last-beat flag per requester (only the granted
//                       requester's bit is used)
//   grant_vector   out  [3:0] one-hot grant, 0 when idle (registered)
//   grant_valid    out  |grant_vector (registered)
//   grant_id       out  [1:0] granted requester; holds last value while idle
//   beat_count     out  [CNT_W-1:0] beats in current grant, 1 on first beat
//   timeout_pulse  out  one-cycle pulse after a grant ended by MAX_HOLD
// ---------------------------------------------------------------------------
module rr_port_scheduler #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              enable,
    input  logic [NREQ-1:0]                   req_vector,
    input  logic [NREQ-1:0]                   eop_vector,
    output logic [NREQ-1:0]                   grant_vector,
    output logic                              grant_valid,
    output logic [1:0]                        grant_id,
    output logic [$clog2(MAX_HOLD+1)-1:0]     beat_count,
    output logic                              timeout_pulse
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] MAX_BEATS = CNT_W'(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q;
    logic [1:0] ptr_q;

    // Returns {found, index} of the first set request bit when searching
    // start, start+1, start+2, start+3 (mod 4). The loop runs backwards so
    // the earliest position in search order is the last one written.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic       rel_eop;
    logic       rel_wd;
    logic       rel_max;
    logic       release_now;
    logic       timeout_rel;
    logic [1:0] search_start;
    logic [2:0] pick;
    logic       win_found;
    logic [1:0] win_idx;

    always_comb begin
        rel_eop      = eop_vector[grant_id];
        rel_wd       = !req_vector[grant_id];
        rel_max      = (beat_count == MAX_BEATS);
        release_now  = (state_q == BUSY) && (rel_eop || rel_wd || rel_max);
        // A timeout is reported only when the hold limit alone ended the grant.
        timeout_rel  = rel_max && !rel_eop && !rel_wd;
        // While busy, the only arbitration that matters is the release-time
        // one, which starts just past the requester being released so that
        // it is considered last.
        search_start = (state_q == BUSY) ? (grant_id + 2'd1) : ptr_q;
        pick         = rr_pick(req_vector, search_start);
        win_found    = pick[2];
        win_idx      = pick[1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            ptr_q         <= 2'd0;
            grant_vector  <= '0;
            grant_valid   <= 1'b0;
            grant_id      <= 2'd0;
            beat_count    <= '0;
            timeout_pulse <= 1'b0;
        end else if (!enable) begin
            timeout_pulse <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_pulse <= 1'b0;
                    if (win_found) begin
                        state_q      <= BUSY;
                        grant_vector <= NREQ'(1) << win_idx;
                        grant_valid  <= 1'b1;
                        grant_id     <= win_idx;
                        beat_count   <= CNT_W'(1);
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        ptr_q         <= grant_id + 2'd1;
                        timeout_pulse <= timeout_rel;
                        if (win_found) begin
                            // Zero-bubble handover to the next winner.
                            grant_vector <= NREQ'(1) << win_idx;
                            grant_valid  <= 1'b1;
                            grant_id     <= win_idx;
                            beat_count   <= CNT_W'(1);
                        end else begin
                            state_q      <= IDLE;
                            grant_vector <= '0;
                            grant_valid  <= 1'b0;
                            beat_count   <= '0;
                        end
                    end else begin
                        timeout_pulse <= 1'b0;
                        beat_count    <= beat_count + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_port_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rr_port_scheduler
//
// Drives directed packet scenarios and randomized traffic into
// rr_port_scheduler and compares every output after every clock edge with a
// behavioural model of the scheduling rules.
// ---------------------------------------------------------------------------
module tb_rr_port_scheduler;

    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = $clog2(MAX_HOLD + 1);

    logic             CLK;
    logic             RST;
    logic             enable;
    logic [3:0]       req_vector;
    logic [3:0]       eop_vector;
    logic [3:0]       grant_vector;
    logic             grant_valid;
    logic [1:0]       grant_id;
    logic [CNT_W-1:0] beat_count;
    logic             timeout_pulse;

    rr_port_scheduler #(
        .NREQ     (4),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .enable        (enable),
        .req_vector    (req_vector),
        .eop_vector    (eop_vector),
        .grant_vector  (grant_vector),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .beat_count    (beat_count),
        .timeout_pulse (timeout_pulse)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who holds the port (-1 = nobody), the priority
    // pointer, beats served, last granted id and the timeout flag.
    int   m_owner;
    int   m_ptr;
    int   m_bc;
    int   m_id;
    bit   m_to;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int s);
        for (int k = 0; k < 4; k++) begin
            if (r[(s + k) % 4]) return (s + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic e,
                              input logic [3:0] rq, input logic [3:0] ep);
        int  w;
        bit  by_eop, by_wd, by_max;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_bc = 0; m_id = 0; m_to = 0;
        end else if (!e) begin
            m_to = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            w = first_from(rq, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_id = w; m_bc = 1;
            end
        end else begin
            by_eop = ep[m_owner];
            by_wd  = !rq[m_owner];
            by_max = (m_bc == MAX_HOLD);
            if (by_eop || by_wd || by_max) begin
                m_to  = by_max && !by_eop && !by_wd;
                m_ptr = (m_owner + 1) % 4;
                w = first_from(rq, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_id = w; m_bc = 1;
                end else begin
                    m_owner = -1; m_bc = 0;
                end
            end else begin
                m_bc++;
                m_to = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic e,
                        input logic [3:0] rq, input logic [3:0] ep);
        logic [3:0] exp_gv;
        RST = r; enable = e; req_vector = rq; eop_vector = ep;
        @(posedge CLK);
        model_edge(r, e, rq, ep);
        #1;
        exp_gv = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk("grant_vector",  32'(grant_vector),  32'(exp_gv));
        chk("grant_valid",   32'(grant_valid),   32'(m_owner >= 0));
        chk("grant_id",      32'(grant_id),      32'(m_id));
        chk("beat_count",    32'(beat_count),    32'(m_bc));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_to));
        chk("onehot",        32'($countones(grant_vector) <= 1), 32'(1));
    endtask

    // n cycles with a fixed request; the granted requester flags eop on
    // the cycle in which it is serving beat eop_at (0 = never).
    task automatic run(input int n, input logic [3:0] rq, input int eop_at);
        logic [3:0] ep;
        for (int i = 0; i < n; i++) begin
            ep = (m_owner >= 0 && m_bc == eop_at) ? (4'b0001 << m_owner) : 4'b0000;
            step(1'b0, 1'b1, rq, ep);
        end
    endtask

    logic [3:0] rreq;
    logic [3:0] reop;
    logic       rrst;
    logic       ren;

    initial begin
        m_owner = -1; m_ptr = 0; m_bc = 0; m_id = 0; m_to = 0;

        // Reset, then a single packet from requester 2 ending at beat 3.
        step(1'b1, 1'b1, 4'b0000, 4'b0000);
        step(1'b1, 1'b1, 4'b0000, 4'b0000);
        run(3, 4'b0100, 3);
        step(1'b0, 1'b1, 4'b0000, 4'b0100);
        run(2, 4'b0000, 0);
        // After requester 2, requester 3 has priority over 0.
        run(2, 4'b1001, 0);

        // All requesting, eop every 2 beats: order 0,1,2,3,0,...
        step(1'b1, 1'b1, 4'b0000, 4'b0000);
        run(18, 4'b1111, 2);

        // Timeout: requester 0 never signals eop.
        step(1'b1, 1'b1, 4'b0000, 4'b0000);
        run(20, 4'b0011, 0);
        chk("timeout_handover_id", 32'(grant_id), 32'(1));

        // Withdrawal of requester 2 at beat 3.
        step(1'b1, 1'b1, 4'b0000, 4'b0000);
        run(3, 4'b0100, 0);
        step(1'b0, 1'b1, 4'b0000, 4'b0000);
        run(2, 4'b0000, 0);

        // Enable freeze for 5 cycles mid-packet.
        step(1'b1, 1'b1, 4'b0000, 4'b0000);
        run(3, 4'b1111, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b1111, 4'b1111);
        run(4, 4'b1111, 0);

        // Reset at beat 4.
        step(1'b1, 1'b1, 4'b0000, 4'b0000);
        run(4, 4'b0010, 0);
        step(1'b1, 1'b1, 4'b0010, 4'b0000);
        run(2, 4'b0110, 0);

        // Random traffic: frequent eop.
        rreq = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            rrst = ($urandom_range(99) == 0);
            ren  = ($urandom_range(9) != 0);
            if ($urandom_range(3) == 0) rreq = 4'($urandom);
            reop = 4'($urandom) & 4'($urandom);
            step(rrst, ren, rreq, reop);
        end

        // Random traffic: rare eop and sticky requests so timeouts occur.
        for (int i = 0; i < 2000; i++) begin
            rrst = ($urandom_range(499) == 0);
            ren  = ($urandom_range(15) != 0);
            if ($urandom_range(29) == 0) rreq = 4'($urandom);
            reop = ($urandom_range(24) == 0) ? 4'($urandom) : 4'b0000;
            step(rrst, ren, rreq, reop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_port_scheduler.md
# rr_port_scheduler

Packet-aware round-robin scheduler for one router output port. Shares the port among 4 input requesters and holds each grant for a whole packet: the grant ends on end-of-packet, on request withdrawal, or when a hold timeout fires. Priority rotates after every release, so the requester just served becomes lowest priority. Sits between the input-port request logic and the output-port mux select.

## Interface
- NREQ, 4, number of requesters; fixed at 4 in this revision.
- MAX_HOLD, 16, maximum beats one grant may last; legal range 2..255.
- CNT_W, $clog2(MAX_HOLD+1), beat-counter width; derived, not overridden.

- CLK  in  1  single clock; all state changes on the posedge.
- RST  in  1  synchronous, active-high reset, sampled on the CLK posedge.
- enable  in  1  active-high; when low, all state is frozen.
- req_vector  in  4  bit i set = requester i wants the port (level).
- eop_vector  in  4  bit i set = current beat of requester i is its last.
- grant_vector  out  4  one-hot grant, or 0 when idle (registered).
- grant_valid  out  1  equals |grant_vector (registered).
- grant_id  out  2  index of the granted requester; holds its last value while idle.
- beat_count  out  CNT_W  beats elapsed in the current grant; 1 on the first granted cycle.
- timeout_pulse  out  1  one-cycle pulse when a grant is ended by MAX_HOLD.

## Operation
- State: FSM {IDLE, BUSY} plus a 2-bit priority pointer ptr.
  - ptr is the highest-priority requester for the next arbitration.
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Reset values: IDLE, ptr=0, grant_vector=0, grant_valid=0, grant_id=0, beat_count=0, timeout_pulse=0.
  - RST wins over enable.
  - RST mid-packet drops the grant at that edge with no timeout_pulse.
- With enable=0, no register changes, except that timeout_pulse clears to 0.
- IDLE, enable=1, req_vector≠0:
  - Winner w is the first set bit in search order.
  - grant_vector=1<<w, grant_id=w, beat_count=1; go to BUSY.
- IDLE, req_vector=0: stay in IDLE.
- BUSY, enable=1, with g=grant_id, the grant is released when any of these holds:
  - (a) eop_vector[g]=1
  - (b) req_vector[g]=0
  - (c) beat_count==MAX_HOLD
- On release:
  - ptr=g+1 (mod 4).
  - timeout_pulse=1 only if (c) holds and neither (a) nor (b) holds.
  - Re-arbitration happens in the same cycle, with search order starting at g+1.
  - If a winner exists, it is granted next cycle with beat_count=1 and the FSM stays in BUSY. This gives a zero-bubble handover.
  - Requester g is considered last. It may win again only if it is the sole requester.
  - With no winner: grant_vector=0 and the FSM goes to IDLE.
- BUSY, no release: beat_count increments; grant is unchanged.
- eop_vector bits of non-granted requesters are ignored.
- beat_count never exceeds MAX_HOLD.

## Timing
- Grant latency: a request sampled at edge k produces grant_vector at k+1.
- The cycle in which eop is presented under grant is the last granted cycle. The grant drops or switches at the next edge.
- Handover is back-to-back: the old grant's last cycle is immediately followed by the new grant's first cycle.
- grant_vector is at most one-hot in every cycle, including the reset cycle.
- timeout_pulse is asserted during the first cycle after a timeout release, concurrent with the next grant or with idle.
- Outputs are driven only from registers.

## Test plan
- Reset and single request:
  - Stimulus: hold RST for 2 cycles, then req_vector=4'b0100 with eop at beat 3.
  - Response: grant_vector=4'b0100 one cycle after the request, beat_count 1,2,3, then 0. Next search starts at requester 3.
- All requesting, eop every 2 beats, 4 packets:
  - Grant order is 0,1,2,3 with zero idle cycles between grants.
  - After the 4th release ptr=0 and the order repeats.
- Timeout:
  - Stimulus: req_vector=4'b0011, requester 0 never asserts eop, MAX_HOLD=16.
  - Response: requester 0 is granted for exactly 16 cycles. Then grant_vector=4'b0010 and timeout_pulse=1 in the same cycle.
- Withdrawal:
  - Stimulus: requester 2 granted, req_vector[2] drops at beat 3.
  - Response: grant leaves requester 2 at the next edge with no timeout_pulse.
- enable freeze:
  - Stimulus: drop enable for 5 cycles mid-packet.
  - Response: grant_vector, beat_count and ptr are unchanged. Counting resumes from the same value when enable returns.
- Reset mid-packet:
  - Stimulus: assert RST at beat 4.
  - Response: all outputs are 0 next cycle and ptr=0.
